uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have one parameter: CLKS_PER_BIT, default 16, fpga_clk cycles per serial bit (even, >= 4).
REQ-002 The module SHALL have port fpga_clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port nrst  input  1  reset, synchronous and active-low.
REQ-004 The module SHALL have port sin  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 The module SHALL have port rx_ack  input  1  consumer acknowledge of the held byte.
REQ-006 The module SHALL have port dout  output  8  last good received byte.
REQ-007 The module SHALL have port rx_valid  output  1  level flag, dout holds an unacknowledged byte.
REQ-008 The module SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 The module SHALL have port overrun_err  output  1  one-cycle pulse, new byte overwrote an unacknowledged byte.

Function
REQ-010 sin SHALL pass through a 2-flop synchronizer (preset high) before any use; "line" below means the synchronized value.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 IDLE -> START SHALL occur only on a line falling edge (previous synced sample 1, current 0); the bit counter clears on entry.
REQ-013 START SHALL wait CLKS_PER_BIT/2 cycles and then sample the line: 0 -> DATA with the counter cleared; 1 -> IDLE (false start, no outputs change).
REQ-014 DATA SHALL sample the line every CLKS_PER_BIT cycles, at the mid-bit point, eight times, shifting each sample into the MSB of an 8-bit shift register with a right shift, so the first bit lands in bit 0.
REQ-015 After the 8th data sample, the FSM SHALL enter STOP, wait CLKS_PER_BIT cycles, then sample the stop bit and return to IDLE.
REQ-016 Stop bit 1: the shift register SHALL load into dout and rx_valid SHALL be set, both visible the cycle after the stop sample.
REQ-017 Stop bit 0: frame_err SHALL pulse for one cycle, and dout, rx_valid and overrun_err SHALL stay unchanged.
REQ-018 rx_valid SHALL clear the cycle after rx_ack is sampled high while rx_valid=1; rx_ack while rx_valid=0 SHALL be ignored.
REQ-019 If a good byte completes while rx_valid=1 and rx_ack=0, dout SHALL be overwritten, rx_valid SHALL stay 1, and overrun_err SHALL pulse one cycle.
REQ-020 If a good byte completes in the same cycle rx_ack is high, the new byte SHALL load, rx_valid SHALL stay 1, and there SHALL be no overrun.
REQ-021 A line held low (break) after a framing error SHALL NOT retrigger START until the line returns high and falls again.
REQ-022 The bit/cycle counter SHALL be ceil(log2(CLKS_PER_BIT)) bits, SHALL wrap to 0 at CLKS_PER_BIT-1, and SHALL never overflow.
REQ-023 The data-bit index SHALL be 3 bits, counting 0..7.

Reset
REQ-024 With nrst=0 at a clock edge: the FSM SHALL go to IDLE, the counters and shift register to 0, dout=8'h00, rx_valid=0, frame_err=0, overrun_err=0, and the synchronizer flops to 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame without any pulse; after release, the receiver SHALL wait for a fresh falling edge.

Structure
REQ-026 Package uart_pkg SHALL hold the rx_state_t enum (IDLE, START, DATA, STOP) and the localparam UART_DEFAULT_CLKS_PER_BIT=16, shared with the transmitter.
REQ-027 The synchronizer SHALL be a separate sub-module, uart_sync2 (2-flop, parameterised reset value); the counters and FSM SHALL stay in uart_rx.

Verification (CLKS_PER_BIT=16, frames driven at exactly 16 clocks/bit)
REQ-028 Send 0xA5 with a good stop bit -> dout=0xA5, rx_valid=1 within 2+16*9.5+2 clocks of the start edge, frame_err=0.
REQ-029 Pulse sin low for 4 clocks, then high -> FSM returns to IDLE from START; rx_valid, dout and the error outputs stay unchanged.
REQ-030 Send 0x3C with the stop bit driven 0 -> one-cycle frame_err; dout and rx_valid keep their previous values; a following 0x11 frame is received correctly.
REQ-031 Send 0x01 then 0xFE with no rx_ack -> one-cycle overrun_err at the second completion, dout=0xFE, rx_valid=1; rx_ack -> rx_valid=0 next cycle.
REQ-032 Assert rx_ack in the exact completion cycle of a second byte -> rx_valid stays 1, no overrun_err, dout holds the new byte.
REQ-033 Assert nrst for 1 cycle mid-DATA of 0x77, then send 0x5A -> no outputs during the aborted frame; dout=0x5A, rx_valid=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
package uart_pkg;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer handshake: held byte, valid level, acknowledge, error pulses.
interface uart_rx_if;
  logic [7:0] dout;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun_err;

  modport master (output dout, rx_valid, frame_err, overrun_err, input rx_ack);
  modport slave  (input dout, rx_valid, frame_err, overrun_err, output rx_ack);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input, reset to a chosen level.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic fpga_clk,
  input  logic nrst,
  input  logic d,
  output logic q
);
  logic s1;

  // Two capture stages; reset value keeps the line at its idle level.
  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, held-byte handshake, framing/overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic      fpga_clk,
  input  logic      nrst,
  input  logic      sin,
  uart_rx_if.master rx
);
  localparam int             CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state, nstate;
  logic          line, line_prev, fall;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    dout_q;
  logic          valid_q, fe_q, ov_q;
  logic          cnt_clr, cnt_inc, bit_clr, shift_en, stop_smp;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .fpga_clk (fpga_clk),
    .nrst     (nrst),
    .d        (sin),
    .q        (line)
  );

  // A start is only a high-to-low transition, so a held-low break never retriggers.
  assign fall = line_prev & ~line;

  // State register plus previous-line sample for edge detection.
  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      state     <= IDLE;
      line_prev <= 1'b1;
    end else begin
      state     <= nstate;
      line_prev <= line;
    end
  end

  // Next-state and datapath strobes; every sample point also restarts the counter.
  always_comb begin
    nstate   = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    stop_smp = 1'b0;
    unique case (state)
      IDLE: if (fall) begin
        nstate  = START;
        cnt_clr = 1'b1;
      end
      START: if (cnt == HALF_M1) begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
        nstate  = line ? IDLE : DATA;
      end else cnt_inc = 1'b1;
      DATA: if (cnt == LAST) begin
        cnt_clr  = 1'b1;
        shift_en = 1'b1;
        if (bit_idx == 3'd7) nstate = STOP;
      end else cnt_inc = 1'b1;
      STOP: if (cnt == LAST) begin
        cnt_clr  = 1'b1;
        stop_smp = 1'b1;
        nstate   = IDLE;
      end else cnt_inc = 1'b1;
      default: nstate = IDLE;
    endcase
  end

  // Bit-timing counter, data-bit index and LSB-first shift register.
  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (bit_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
      if (shift_en) shreg <= {line, shreg[7:1]};
    end
  end

  // Output holding register: load on good stop, clear on ack, single-cycle error pulses.
  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      ov_q <= 1'b0;
      if (valid_q && rx.rx_ack) valid_q <= 1'b0;
      if (stop_smp) begin
        if (line) begin
          dout_q  <= shreg;
          valid_q <= 1'b1;
          // An ack in the completion cycle consumes the old byte, so no overrun.
          ov_q    <= valid_q & ~rx.rx_ack;
        end else begin
          fe_q <= 1'b1;
        end
      end
    end
  end

  assign rx.dout        = dout_q;
  assign rx.rx_valid    = valid_q;
  assign rx.frame_err   = fe_q;
  assign rx.overrun_err = ov_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames vs. a byte-level model.
module tb_uart_rx;
  localparam int CPB = 16;
  // Stop-bit sample edge, counted from the edge after which sin first falls:
  // 2 synchronizer stages + edge detect + half bit + 8 data bits + stop bit.
  localparam int COMPLETE_I = 2 + 1 + CPB / 2 + 8 * CPB + CPB - 1;
  localparam int LAT_MAX    = 2 + CPB * 9 + CPB / 2 + 2;

  logic fpga_clk = 1'b0;
  logic nrst;
  logic sin;
  uart_rx_if rif ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .fpga_clk (fpga_clk),
    .nrst     (nrst),
    .sin      (sin),
    .rx       (rif)
  );

  always #5 fpga_clk = ~fpga_clk;

  int n_asrt = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int lat;

  // Reference model state: what the consumer should see.
  logic [7:0] m_dout;
  logic       m_valid;

  // Count every cycle each pulse output is high, so a stretched pulse shows up as >1.
  always @(negedge fpga_clk) begin
    if (rif.frame_err === 1'b1)   fe_cnt++;
    if (rif.overrun_err === 1'b1) ov_cnt++;
  end

  task automatic tick();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one 8N1 frame; ack_at is the frame cycle to pulse rx_ack (-1: none);
  // brk holds the line low afterwards for that many cycles. Then predict and check.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic stopb,
                           input int ack_at, input int brk);
    logic [9:0] bits;
    int fe0, ov0, exp_fe, exp_ov;
    logic pv;
    bits = {stopb, b, 1'b0};
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    pv  = rif.rx_valid;
    lat = -1;
    for (int i = 0; i < 10 * CPB; i++) begin
      sin        = bits[i / CPB];
      rif.rx_ack = (i == ack_at);
      tick();
      if (lat < 0 && !pv && rif.rx_valid === 1'b1) lat = i + 1;
    end
    rif.rx_ack = 1'b0;
    sin = 1'b0;
    repeat (brk) tick();
    sin = 1'b1;
    repeat (8) tick();

    // Model: order ack events around the completion point.
    exp_fe = stopb ? 0 : 1;
    exp_ov = 0;
    if (ack_at >= 0 && ack_at < COMPLETE_I) m_valid = 1'b0;
    if (stopb) begin
      exp_ov  = (m_valid && ack_at != COMPLETE_I) ? 1 : 0;
      m_dout  = b;
      m_valid = 1'b1;
    end else if (ack_at == COMPLETE_I) begin
      m_valid = 1'b0;
    end
    if (ack_at > COMPLETE_I) m_valid = 1'b0;

    chk({tag, ".dout"},      rif.dout,        m_dout);
    chk({tag, ".rx_valid"},  rif.rx_valid,    m_valid);
    chk({tag, ".frame_err"}, fe_cnt - fe0,    exp_fe);
    chk({tag, ".overrun"},   ov_cnt - ov0,    exp_ov);
  endtask

  task automatic ack_pulse();
    rif.rx_ack = 1'b1;
    tick();
    rif.rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    int fe0, ov0;
    logic [7:0] rb;
    logic       rs;
    int         ra;
    nrst = 1'b0;
    sin = 1'b1;
    rif.rx_ack = 1'b0;
    m_dout = 8'h00;
    m_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst.dout",      rif.dout,        8'h00);
    chk("rst.rx_valid",  rif.rx_valid,    1'b0);
    chk("rst.frame_err", rif.frame_err,   1'b0);
    chk("rst.overrun",   rif.overrun_err, 1'b0);
    nrst = 1'b1;
    repeat (5) tick();

    // Good frame and latency bound
    run_frame("a5", 8'hA5, 1'b1, -1, 0);
    chk("a5.latency_ok", (lat > 0 && lat <= LAT_MAX), 1'b1);

    // False start: 4-cycle glitch
    fe0 = fe_cnt; ov0 = ov_cnt;
    sin = 1'b0;
    repeat (4) tick();
    sin = 1'b1;
    repeat (3 * CPB) tick();
    chk("glitch.dout",     rif.dout,     m_dout);
    chk("glitch.rx_valid", rif.rx_valid, m_valid);
    chk("glitch.pulses",   (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    ack_pulse();
    chk("glitch.ack", rif.rx_valid, 1'b0);

    // Framing error followed by a 3-bit break, then a good frame
    run_frame("3c_bad", 8'h3C, 1'b0, -1, 3 * CPB);
    run_frame("11", 8'h11, 1'b1, -1, 0);
    ack_pulse();

    // Overrun: two bytes with no ack, then ack clears next cycle
    run_frame("01", 8'h01, 1'b1, -1, 0);
    run_frame("fe_ovr", 8'hFE, 1'b1, -1, 0);
    rif.rx_ack = 1'b1;
    tick();
    rif.rx_ack = 1'b0;
    m_valid = 1'b0;
    chk("ovr.ack_clear", rif.rx_valid, 1'b0);
    // Ack while nothing is held is ignored
    rif.rx_ack = 1'b1;
    tick();
    rif.rx_ack = 1'b0;
    chk("idle_ack.valid", rif.rx_valid, 1'b0);

    // Ack in the exact completion cycle of a second byte
    run_frame("42", 8'h42, 1'b1, -1, 0);
    run_frame("99_ack", 8'h99, 1'b1, COMPLETE_I, 0);
    ack_pulse();

    // Reset mid-DATA of 0x77 (during a high data bit), sender abandons the frame
    fe0 = fe_cnt; ov0 = ov_cnt;
    rb = 8'h77;
    sin = 1'b0;
    repeat (CPB) tick();
    sin = rb[0];
    repeat (CPB) tick();
    sin = rb[1];
    repeat (CPB / 2) tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    sin = 1'b1;
    m_dout = 8'h00;
    m_valid = 1'b0;
    repeat (12 * CPB) tick();
    chk("abort.pulses",   (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    chk("abort.rx_valid", rif.rx_valid, 1'b0);
    chk("abort.dout",     rif.dout,     8'h00);
    run_frame("5a", 8'h5A, 1'b1, -1, 0);

    // Random frames against the model
    for (int k = 0; k < 10; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: ra = -1;
        1: ra = 40;
        2: ra = COMPLETE_I;
        default: ra = COMPLETE_I + 3;
      endcase
      run_frame($sformatf("rnd%0d", k), rb, rs, ra, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
